// File: rtl/hilo_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// hilo_div_unit_pkg : shared state encoding and constants for the HI/LO unit
// Rev 1.0
// ============================================================================
package hilo_div_unit_pkg;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  // ALU op codes that route a divide to this unit
  localparam logic [5:0] DIV_CONTROL  = 6'h1A;
  localparam logic [5:0] DIVU_CONTROL = 6'h1B;

  typedef enum logic [1:0] {
    HILO_IDLE = 2'd0,
    HILO_RUN  = 2'd1,
    HILO_DONE = 2'd2
  } hilo_state_e;

endpackage
`default_nettype wire

// File: rtl/hilo_div_unit_div_core.sv
`default_nettype none
// ============================================================================
// hilo_div_unit_div_core : restoring divider datapath, iteration counter, sign fix-up
// Rev 1.0
// ============================================================================
module hilo_div_unit_div_core
  import hilo_div_unit_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] DIVZ_QUOT = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              abort_i,
  output logic [DATA_W-1:0] quo_o,
  output logic [DATA_W-1:0] rem_o,
  output logic              done_o
);

  logic              run_q, run_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;

  logic              w_a_neg, w_b_neg, w_b_zero, w_last;
  logic [DATA_W-1:0] w_a_abs, w_b_abs;
  logic [DATA_W:0]   w_rem_shift, w_trial;

  assign w_a_neg  = signed_i & a_i[DATA_W-1];
  assign w_b_neg  = signed_i & b_i[DATA_W-1];
  // abs of the most negative value wraps to itself and is then used unsigned
  assign w_a_abs  = w_a_neg ? (~a_i + 1'b1) : a_i;
  assign w_b_abs  = w_b_neg ? (~b_i + 1'b1) : b_i;
  assign w_b_zero = (b_i == '0);
  assign w_last   = run_q && (cnt_q == CNT_W'(DIV_ITERS - 1));

  // Partial remainder is always below the divisor, so a 33-bit trial
  // subtract yields a borrow exactly when the shifted remainder is too small.
  assign w_rem_shift = {rem_q, quo_q[DATA_W-1]};
  assign w_trial     = w_rem_shift - {1'b0, dvs_q};

  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if (start_i) begin
      cnt_d = '0;
      if (w_b_zero) begin
        run_d  = 1'b0;
        quo_d  = DIVZ_QUOT;
        rem_d  = a_i;
        qneg_d = 1'b0;
        rneg_d = 1'b0;
      end else begin
        run_d  = 1'b1;
        quo_d  = w_a_abs;
        rem_d  = '0;
        dvs_d  = w_b_abs;
        qneg_d = w_a_neg ^ w_b_neg;
        rneg_d = w_a_neg;
      end
    end else if (abort_i) begin
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q + 1'b1;
      if (w_trial[DATA_W]) begin
        rem_d = w_rem_shift[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
      end else begin
        rem_d = w_trial[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b1};
      end
      if (w_last) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end

  assign quo_o  = qneg_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_o  = rneg_q ? (~rem_q + 1'b1) : rem_q;
  assign done_o = w_last;

endmodule
`default_nettype wire

// File: rtl/hilo_div_unit.sv
`default_nettype none
// ============================================================================
// hilo_div_unit : HI/LO architectural registers with bypassed reads and a DIV/DIVU engine
// Rev 1.0
// ============================================================================
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] DIVZ_QUOT = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        hilo_we,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] div_a,
  input  logic [DATA_W-1:0] div_b,
  input  logic              flush,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_busy,
  output logic              stall_req,
  output logic              div_done
);

  hilo_state_e       state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic              w_idle, w_accept, w_core_last, w_commit;
  logic [DATA_W-1:0] w_core_quo, w_core_rem;

  assign w_idle   = (state_q == HILO_IDLE);
  assign w_accept = w_idle & div_start & ~flush;
  assign w_commit = (state_q == HILO_DONE) & ~flush;

  hilo_div_unit_div_core #(
    .DATA_W    (DATA_W),
    .DIVZ_QUOT (DIVZ_QUOT)
  ) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .start_i  (w_accept),
    .signed_i (div_signed),
    .a_i      (div_a),
    .b_i      (div_b),
    .abort_i  (flush),
    .quo_o    (w_core_quo),
    .rem_o    (w_core_rem),
    .done_o   (w_core_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      HILO_IDLE: begin
        if (w_accept) state_d = (div_b == '0) ? HILO_DONE : HILO_RUN;
      end
      HILO_RUN: begin
        if (flush)            state_d = HILO_IDLE;
        else if (w_core_last) state_d = HILO_DONE;
      end
      HILO_DONE: state_d = HILO_IDLE;
      default:   state_d = HILO_IDLE;
    endcase
  end

  // The divide result belongs to the younger instruction, so it overrides
  // any simultaneous MT*/MULT writeback on both halves.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hilo_we[1]) hi_d = hi_in;
    if (hilo_we[0]) lo_d = lo_in;
    if (w_commit) begin
      hi_d = w_core_rem;
      lo_d = w_core_quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HILO_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi        = hilo_we[1] ? hi_in : hi_q;
  assign lo        = hilo_we[0] ? lo_in : lo_q;
  assign div_busy  = ~w_idle;
  assign stall_req = div_busy | w_accept;
  assign div_done  = (state_q == HILO_DONE);

endmodule
`default_nettype wire

// File: tb/tb_hilo_div_unit.sv
`default_nettype none
// ============================================================================
// tb_hilo_div_unit : vector table, random divides against an arithmetic model, corner sequences
// Rev 1.0
// ============================================================================
module tb_hilo_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  hilo_we;
  logic [31:0] hi_in, lo_in;
  logic        div_start, div_signed;
  logic [31:0] div_a, div_b;
  logic        flush;
  logic [31:0] hi, lo;
  logic        div_busy, stall_req, div_done;

  int checks   = 0;
  int failures = 0;

  hilo_div_unit #(
    .DATA_W    (32),
    .DIVZ_QUOT (32'hFFFFFFFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hilo_we    (hilo_we),
    .hi_in      (hi_in),
    .lo_in      (lo_in),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_a      (div_a),
    .div_b      (div_b),
    .flush      (flush),
    .hi         (hi),
    .lo         (lo),
    .div_busy   (div_busy),
    .stall_req  (stall_req),
    .div_done   (div_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: architectural divide rules expressed with plain arithmetic
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mhi, output logic [31:0] mlo);
    if (b == 32'd0) begin
      mlo = 32'hFFFFFFFF;
      mhi = a;
    end else if (!s) begin
      mlo = a / b;
      mhi = a % b;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      mlo = 32'h80000000;
      mhi = 32'd0;
    end else begin
      mlo = $signed(a) / $signed(b);
      mhi = $signed(a) % $signed(b);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    hilo_we = 2'b11; hi_in = h; lo_in = l;
    cyc();
    hilo_we = 2'b00;
  endtask

  // Issues one divide and follows it until stall_req drops; flush_at is the
  // cycle index (0 = issue cycle) at which to assert flush, -1 for none.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input logic we_in_done,
                         output int stalls, output int dones);
    logic ended;
    stalls = 0; dones = 0; ended = 1'b0;
    div_start = 1'b1; div_signed = s; div_a = a; div_b = b;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (!stall_req) begin
        ended = 1'b1;
        break;
      end
      stalls++;
      if (div_done) dones++;
      if (c == flush_at) flush = 1'b1;
      if (div_done && we_in_done) begin
        hilo_we = 2'b11; hi_in = $urandom; lo_in = $urandom;
      end
      cyc();
      div_start = 1'b0; flush = 1'b0; hilo_we = 2'b00;
    end
    checks++;
    if (!ended) begin
      failures++;
      $display("FAIL div_timeout actual=stall_req_stuck expected=release");
    end
  endtask

  initial begin
    int          st, dn;
    logic [31:0] eh, el, ph, pl, ra, rb;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         34};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   34};
    vecs[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   34};
    vecs[3] = '{1'b1, 32'h12345678,   32'd0,          32'h12345678,   32'hFFFFFFFF,   2};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF,   34};
    vecs[5] = '{1'b0, 32'd5,          32'd10,         32'd5,          32'd0,          34};
    vecs[6] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   34};
    vecs[7] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          34};
    vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          32'd1,          34};
    vecs[9] = '{1'b0, 32'd9,          32'd0,          32'd9,          32'hFFFFFFFF,   2};

    rst = 1'b1; hilo_we = 2'b00; hi_in = '0; lo_in = '0;
    div_start = 1'b0; div_signed = 1'b0; div_a = '0; div_b = '0; flush = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset after random writes
    for (int i = 0; i < 3; i++) set_hilo($urandom, $urandom);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, div_busy}, 32'd0);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    chk("reset_done", {31'd0, div_done}, 32'd0);
    cyc();

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].s, vecs[i].a, vecs[i].b, -1, 1'b0, st, dn);
      chk($sformatf("vec%0d_stalls", i), 32'(st), 32'(vecs[i].stalls));
      chk($sformatf("vec%0d_dones", i), 32'(dn), 32'd1);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end

    // Randomised divides against the model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = $urandom_range(1, 20);
        2:       rb = 32'd0 - 32'($urandom_range(1, 20));
        default: rb = 32'd0;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
      div_signed = $urandom_range(0, 1);
      model(div_signed, ra, rb, eh, el);
      run_div(div_signed, ra, rb, -1, 1'b0, st, dn);
      chk($sformatf("rnd%0d_stalls", i), 32'(st), (rb == 0) ? 32'd2 : 32'd34);
      chk($sformatf("rnd%0d_hi", i), hi, eh);
      chk($sformatf("rnd%0d_lo", i), lo, el);
    end

    // Flush at RUN counter 10: abort, no write, no done
    set_hilo(32'h11111111, 32'h22222222);
    run_div(1'b0, 32'd100, 32'd7, 11, 1'b0, st, dn);
    chk("flush_run_stalls", 32'(st), 32'd12);
    chk("flush_run_dones", 32'(dn), 32'd0);
    chk("flush_run_busy", {31'd0, div_busy}, 32'd0);
    chk("flush_run_hi", hi, 32'h11111111);
    chk("flush_run_lo", lo, 32'h22222222);

    // Flush in the DONE cycle suppresses the write
    run_div(1'b0, 32'd100, 32'd7, 33, 1'b0, st, dn);
    chk("flush_done_dones", 32'(dn), 32'd1);
    chk("flush_done_hi", hi, 32'h11111111);
    chk("flush_done_lo", lo, 32'h22222222);

    // Flush in IDLE suppresses div_start
    div_start = 1'b1; div_a = 32'd100; div_b = 32'd7; flush = 1'b1;
    #1;
    chk("flush_idle_stall", {31'd0, stall_req}, 32'd0);
    cyc();
    div_start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_idle_busy", {31'd0, div_busy}, 32'd0);

    // Write-first bypass on HI only
    ph = hi; pl = lo;
    hilo_we = 2'b10; hi_in = 32'hDEADBEEF; lo_in = 32'h33333333;
    #1;
    chk("bypass_hi", hi, 32'hDEADBEEF);
    chk("bypass_lo", lo, pl);
    cyc();
    #1;
    chk("bypass_hi_kept", hi, 32'hDEADBEEF);
    chk("bypass_lo_kept", lo, pl);
    chk("bypass_prev_hi_differs", {31'd0, ph == 32'hDEADBEEF}, 32'd0);

    // hilo_we collides with the DONE cycle: divider wins
    run_div(1'b0, 32'd100, 32'd7, -1, 1'b1, st, dn);
    chk("collide_hi", hi, 32'd2);
    chk("collide_lo", lo, 32'd14);

    // Reset mid-divide aborts and clears
    set_hilo(32'h55555555, 32'h66666666);
    div_start = 1'b1; div_signed = 1'b0; div_a = 32'd1000; div_b = 32'd3;
    cyc();
    div_start = 1'b0;
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, div_busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    repeat (40) begin
      #1;
      chk("rst_mid_no_done", {31'd0, div_done}, 32'd0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
